// File: rtl/top_module_imp_pkg.sv
// Shared constants and pixel type for the 3x3 sliding-window generator.
package top_module_imp_pkg;

    localparam int DW    = 8;
    localparam int IMG_W = 256;

    typedef logic [DW-1:0] pixel_t;

    // Pointer width for a circular store of n entries (at least one bit).
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row delay: circular store of IMG_W pixels with a single wrapping write pointer.
module line_buffer
    import top_module_imp_pkg::*;
#(
    parameter int DW    = top_module_imp_pkg::DW,
    parameter int IMG_W = top_module_imp_pkg::IMG_W
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam int PW = ptr_width(IMG_W);

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [DW-1:0] mem_q [IMG_W];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (wr_ptr_q == PW'(IMG_W - 1)) begin
            wr_ptr_d = '0;
        end
    end

    // The slot about to be overwritten holds the pixel written IMG_W edges ago,
    // so reading it before the write gives exactly one row of delay.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            mem_q[wr_ptr_q]  <= din;
        end
    end

    assign dout = mem_q[wr_ptr_q];

endmodule

// File: rtl/top_module_imp.sv
// 3x3 pixel window from a raster stream: two cascaded line buffers feeding three 3-tap shift registers.
module top_module_imp
    import top_module_imp_pkg::*;
#(
    parameter int DW    = top_module_imp_pkg::DW,
    parameter int IMG_W = top_module_imp_pkg::IMG_W
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [DW-1:0] dina,
    output logic [DW-1:0] out1,
    output logic [DW-1:0] out2,
    output logic [DW-1:0] out3,
    output logic [DW-1:0] out4,
    output logic [DW-1:0] out5,
    output logic [DW-1:0] out6,
    output logic [DW-1:0] out7,
    output logic [DW-1:0] out8,
    output logic [DW-1:0] out9
);

    logic [DW-1:0] row1_dout;
    logic [DW-1:0] row2_dout;

    logic [DW-1:0] out1_q, out2_q, out3_q;
    logic [DW-1:0] out4_q, out5_q, out6_q;
    logic [DW-1:0] out7_q, out8_q, out9_q;

    line_buffer #(.DW(DW), .IMG_W(IMG_W)) u_line_a (
        .CLK   (CLK),
        .RST_N (RST_N),
        .din   (dina),
        .dout  (row1_dout)
    );

    line_buffer #(.DW(DW), .IMG_W(IMG_W)) u_line_b (
        .CLK   (CLK),
        .RST_N (RST_N),
        .din   (row1_dout),
        .dout  (row2_dout)
    );

    // Buffer outputs already carry the pixel due at the next edge, so each
    // row's newest tap registers it directly, matching the dina -> out9 timing.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out1_q <= '0; out2_q <= '0; out3_q <= '0;
            out4_q <= '0; out5_q <= '0; out6_q <= '0;
            out7_q <= '0; out8_q <= '0; out9_q <= '0;
        end else begin
            out9_q <= dina;
            out8_q <= out9_q;
            out7_q <= out8_q;
            out6_q <= row1_dout;
            out5_q <= out6_q;
            out4_q <= out5_q;
            out3_q <= row2_dout;
            out2_q <= out3_q;
            out1_q <= out2_q;
        end
    end

    assign out1 = out1_q;
    assign out2 = out2_q;
    assign out3 = out3_q;
    assign out4 = out4_q;
    assign out5 = out5_q;
    assign out6 = out6_q;
    assign out7 = out7_q;
    assign out8 = out8_q;
    assign out9 = out9_q;

endmodule

// File: tb/tb_top_module_imp.sv
// Directed and random stimulus for the 3x3 window generator, checked against a delay-line scoreboard.
module tb_top_module_imp;

    localparam int DW    = 8;
    localparam int W     = 4;
    localparam int HLEN  = 2 * W + 3;

    typedef logic [8:0][DW-1:0] win_t;   // index 0 = out1 ... index 8 = out9

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [DW-1:0] dina = '0;
    logic [DW-1:0] out1, out2, out3, out4, out5, out6, out7, out8, out9;
    win_t          obs;

    int            checks = 0;
    int            errors = 0;
    int            hist [HLEN];
    win_t          sb_q [$];

    top_module_imp #(.DW(DW), .IMG_W(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .dina  (dina),
        .out1  (out1), .out2 (out2), .out3 (out3),
        .out4  (out4), .out5 (out5), .out6 (out6),
        .out7  (out7), .out8 (out8), .out9 (out9)
    );

    always #5 CLK = ~CLK;

    assign obs = {out9, out8, out7, out6, out5, out4, out3, out2, out1};

    task automatic check_win(input string tag, input win_t exp);
        for (int i = 0; i < 9; i++) begin
            checks++;
            assert (obs[i] === exp[i]) else begin
                errors++;
                $error("FAIL %s out%0d: observed %0d expected %0d", tag, i + 1, obs[i], exp[i]);
            end
        end
        $display("%t %s: out1..out9 = %0d %0d %0d %0d %0d %0d %0d %0d %0d", $time, tag,
                 obs[0], obs[1], obs[2], obs[3], obs[4], obs[5], obs[6], obs[7], obs[8]);
    endtask

    task automatic model_clear();
        for (int i = 0; i < HLEN; i++) hist[i] = 0;
        sb_q.delete();
    endtask

    // Drive one pixel, push the model's expected window, then compare after the edge.
    task automatic step(input logic [DW-1:0] px, input string tag);
        win_t e;
        win_t got;
        dina = px;
        for (int i = HLEN - 1; i > 0; i--) hist[i] = hist[i - 1];
        hist[0] = int'(px);
        e[8] = DW'(hist[0]);         e[7] = DW'(hist[1]);         e[6] = DW'(hist[2]);
        e[5] = DW'(hist[W]);         e[4] = DW'(hist[W + 1]);     e[3] = DW'(hist[W + 2]);
        e[2] = DW'(hist[2 * W]);     e[1] = DW'(hist[2 * W + 1]); e[0] = DW'(hist[2 * W + 2]);
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        got = sb_q.pop_front();
        check_win(tag, got);
    endtask

    initial begin
        win_t zero_w;
        win_t fix_w;
        zero_w = '0;
        model_clear();

        // Reset held, then released with no edge afterwards.
        repeat (3) @(posedge CLK);
        #1;
        check_win("reset_held", zero_w);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check_win("release_no_edge", zero_w);

        // Ramp to edge 9 and 12 with independent fixed expectations.
        for (int k = 1; k <= 9; k++) step(DW'(k), "ramp");
        fix_w = {8'd9, 8'd8, 8'd7, 8'd5, 8'd4, 8'd3, 8'd1, 8'd0, 8'd0};
        check_win("ramp_edge9", fix_w);
        for (int k = 10; k <= 12; k++) step(DW'(k), "ramp");
        fix_w = {8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6, 8'd4, 8'd3, 8'd2};
        check_win("ramp_edge12", fix_w);

        // Constant 0xFF long enough to flush all history.
        for (int k = 0; k < 11; k++) step(8'hFF, "const_ff");
        fix_w = {9{8'hFF}};
        check_win("const_ff_final", fix_w);

        // Reset mid-ramp between edges: outputs clear immediately.
        for (int k = 1; k <= 6; k++) step(DW'(k + 20), "ramp2");
        #2;
        RST_N = 1'b0;
        #1;
        check_win("async_reset", zero_w);
        model_clear();
        @(negedge CLK);
        RST_N = 1'b1;
        step(8'd50, "resume");
        fix_w = '0;
        fix_w[8] = 8'd50;
        check_win("resume_edge1", fix_w);

        // Random stream against the delay-line model.
        for (int k = 0; k < 1000; k++) step(DW'($urandom_range(0, 255)), "random");

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0d entries expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
